// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Control vector produced by the output decoder.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for every opcode the FSM knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle FSM and the datapath/memory.
interface multi_cycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;

    // Controller side.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mdr_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, bus_error, state
    );

    // Datapath side.
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mdr_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, bus_error, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: state (plus mem_ready for access-completion
// pulses) to control vector. Reset forces everything low.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   reset,
    output ctrl_t  ctrl
);

    // Per-state control decode; unlisted fields stay 0.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCS_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_ADDR, S_ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_READ: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                    ctrl.mdr_write = mem_ready;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCS_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCS_JUMP;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main multi-cycle MIPS control FSM: state register, memory wait
// counter with optional timeout, and next-state logic.
module multi_cycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int TMR_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_cycle_control_if.master bus
);

    // Terminal count is one below the limit so the timeout fires after
    // exactly WAIT_LIMIT waiting cycles.
    localparam logic [TMR_W-1:0] LIM_M1 = TMR_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t           state;
    logic [TMR_W-1:0] wait_cnt;
    logic             bus_error;
    ctrl_t            ctrl;
    logic             mem_state;
    logic             waiting;
    logic             timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign waiting   = mem_state && !bus.mem_ready;
    // mem_ready on the terminal cycle clears waiting, so it beats the timeout.
    assign timeout   = (WAIT_LIMIT != 0) && waiting && (wait_cnt == LIM_M1);

    // State register, wait counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else if (timeout) begin
            state     <= S_HALT;
            wait_cnt  <= '0;
            bus_error <= 1'b1;
        end else begin
            wait_cnt <= waiting ? wait_cnt + TMR_W'(1) : '0;
            case (state)
                S_FETCH:     if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EX;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state <= (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: if (bus.mem_ready) state <= S_FETCH;
                S_EXECUTE:   state <= S_R_WB;
                S_R_WB:      state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_JUMP:      state <= S_FETCH;
                S_ADDI_EX:   state <= S_ADDI_WB;
                S_ADDI_WB:   state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    // Illegal opcode is flagged during the DECODE cycle itself.
    assign bus.illegal_op    = !reset && (state == S_DECODE) && !op_legal(bus.opcode);

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mdr_write     = ctrl.mdr_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.bus_error     = bus_error;
    assign bus.state         = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-cycle vector table on a no-timeout
// instance, plus hand sequences for reset abort and the wait timeout.
module tb_multi_cycle_control;

    // Control word: pw pwc iod mr mw irw mdw m2r rd rw asa | asb | aop | psrc | ill berr
    localparam logic [18:0] E_ZERO = 19'd0;
    localparam logic [18:0] E_F1   = 19'b1_0_0_1_0_1_0_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] E_F0   = 19'b0_0_0_1_0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] E_DEC  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [18:0] E_ILL  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [18:0] E_MADR = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [18:0] E_MRD0 = 19'b0_0_1_1_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MRD1 = 19'b0_0_1_1_0_0_1_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_MWB  = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [18:0] E_MWR  = 19'b0_0_1_0_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] E_EXE  = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [18:0] E_RWB  = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [18:0] E_BR   = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [18:0] E_JMP  = 19'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
    localparam logic [18:0] E_AWB  = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [18:0] E_HALT = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    localparam int NV = 32;

    logic clk = 1'b0;
    logic rst0, rst4;
    int   checks = 0;
    int   passed = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    multi_cycle_control_if m0 ();
    multi_cycle_control_if m4 ();

    multi_cycle_control #(.WAIT_LIMIT(0), .TMR_W(8)) dut0 (.clk(clk), .reset(rst0), .bus(m0));
    multi_cycle_control #(.WAIT_LIMIT(4), .TMR_W(8)) dut4 (.clk(clk), .reset(rst4), .bus(m4));

    logic [18:0] act0, act4;
    assign act0 = {m0.pc_write, m0.pc_write_cond, m0.i_or_d, m0.mem_read, m0.mem_write,
                   m0.ir_write, m0.mdr_write, m0.mem_to_reg, m0.reg_dst, m0.reg_write,
                   m0.alu_src_a, m0.alu_src_b, m0.alu_op, m0.pc_source, m0.illegal_op,
                   m0.bus_error};
    assign act4 = {m4.pc_write, m4.pc_write_cond, m4.i_or_d, m4.mem_read, m4.mem_write,
                   m4.ir_write, m4.mdr_write, m4.mem_to_reg, m4.reg_dst, m4.reg_write,
                   m4.alu_src_a, m4.alu_src_b, m4.alu_op, m4.pc_source, m4.illegal_op,
                   m4.bus_error};

    task automatic chk(input string name, input int idx, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{6'h23, 1'b1, 4'd0,  E_F1};
        tbl[1]  = '{6'h23, 1'b1, 4'd1,  E_DEC};
        tbl[2]  = '{6'h23, 1'b1, 4'd2,  E_MADR};
        tbl[3]  = '{6'h23, 1'b0, 4'd3,  E_MRD0};
        tbl[4]  = '{6'h23, 1'b1, 4'd3,  E_MRD1};
        tbl[5]  = '{6'h23, 1'b1, 4'd4,  E_MWB};
        tbl[6]  = '{6'h2B, 1'b1, 4'd0,  E_F1};
        tbl[7]  = '{6'h2B, 1'b0, 4'd1,  E_DEC};
        tbl[8]  = '{6'h2B, 1'b1, 4'd2,  E_MADR};
        tbl[9]  = '{6'h2B, 1'b0, 4'd5,  E_MWR};
        tbl[10] = '{6'h2B, 1'b0, 4'd5,  E_MWR};
        tbl[11] = '{6'h2B, 1'b0, 4'd5,  E_MWR};
        tbl[12] = '{6'h2B, 1'b1, 4'd5,  E_MWR};
        tbl[13] = '{6'h04, 1'b1, 4'd0,  E_F1};
        tbl[14] = '{6'h04, 1'b0, 4'd1,  E_DEC};
        tbl[15] = '{6'h04, 1'b1, 4'd8,  E_BR};
        tbl[16] = '{6'h02, 1'b1, 4'd0,  E_F1};
        tbl[17] = '{6'h02, 1'b1, 4'd1,  E_DEC};
        tbl[18] = '{6'h02, 1'b0, 4'd9,  E_JMP};
        tbl[19] = '{6'h00, 1'b1, 4'd0,  E_F1};
        tbl[20] = '{6'h00, 1'b1, 4'd1,  E_DEC};
        tbl[21] = '{6'h00, 1'b0, 4'd6,  E_EXE};
        tbl[22] = '{6'h00, 1'b1, 4'd7,  E_RWB};
        tbl[23] = '{6'h08, 1'b1, 4'd0,  E_F1};
        tbl[24] = '{6'h08, 1'b1, 4'd1,  E_DEC};
        tbl[25] = '{6'h08, 1'b1, 4'd10, E_MADR};
        tbl[26] = '{6'h08, 1'b1, 4'd11, E_AWB};
        tbl[27] = '{6'h3F, 1'b1, 4'd0,  E_F1};
        tbl[28] = '{6'h3F, 1'b1, 4'd1,  E_ILL};
        tbl[29] = '{6'h00, 1'b0, 4'd0,  E_F0};
        tbl[30] = '{6'h00, 1'b1, 4'd0,  E_F1};
        tbl[31] = '{6'h00, 1'b1, 4'd1,  E_DEC};

        rst0 = 1'b1; m0.mem_ready = 1'b1; m0.opcode = 6'h23;
        rst4 = 1'b1; m4.mem_ready = 1'b0; m4.opcode = 6'h00;

        // Reset held three cycles: every strobe and enable low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ctl", i, act0, E_ZERO);
        end
        @(posedge clk);
        #1;
        rst0 = 1'b0;

        // Instruction vectors, one row per cycle.
        for (int i = 0; i < NV; i++) begin
            m0.opcode    = tbl[i].op;
            m0.mem_ready = tbl[i].rdy;
            @(negedge clk);
            chk("vec_state", i, {15'd0, m0.state}, {15'd0, tbl[i].st});
            chk("vec_ctl", i, act0, tbl[i].ctl);
            next_cycle();
        end

        // Reset in R_WB aborts the writeback.
        @(negedge clk);
        chk("abort_exe_state", 0, {15'd0, m0.state}, 19'd6);
        next_cycle();
        rst0 = 1'b1;
        @(negedge clk);
        chk("abort_state", 0, {15'd0, m0.state}, 19'd7);
        chk("abort_ctl", 0, act0, E_ZERO);
        next_cycle();
        rst0 = 1'b0;
        @(negedge clk);
        chk("abort_after_state", 0, {15'd0, m0.state}, 19'd0);
        chk("abort_after_ctl", 0, act0, E_F1);

        // Timeout: four waiting FETCH cycles, then HALT with bus_error.
        next_cycle();
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_wait_state", i, {15'd0, m4.state}, 19'd0);
            chk("to_wait_ctl", i, act4, E_F0);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_state", i, {15'd0, m4.state}, 19'd12);
            chk("halt_ctl", i, act4, E_HALT);
            next_cycle();
            m4.mem_ready = 1'b1;
        end

        // Reset clears HALT and bus_error.
        rst4 = 1'b1;
        next_cycle();
        rst4 = 1'b0;
        m4.mem_ready = 1'b0;
        @(negedge clk);
        chk("halt_clr_state", 0, {15'd0, m4.state}, 19'd0);
        chk("halt_clr_ctl", 0, act4, E_F0);

        // mem_ready on the last allowed cycle wins over the timeout.
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk("edge_wait_state", i, {15'd0, m4.state}, 19'd0);
        end
        next_cycle();
        m4.mem_ready = 1'b1;
        @(negedge clk);
        chk("edge_ready_ctl", 0, act4, E_F1);
        next_cycle();
        @(negedge clk);
        chk("edge_dec_state", 0, {15'd0, m4.state}, 19'd1);
        chk("edge_dec_ctl", 0, act4, E_DEC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control finite-state machine for the multi-cycle MIPS CPU. It sequences the shared ALU, the memory port, the instruction register, the register file and the PC through fetch, decode, execute, memory and writeback steps for R-type, lw, sw, beq, j and addi. It drives the ALU B-operand select, which routes the 32-bit sign-extended immediate into the ALU. It also handshakes with a variable-latency memory and has an optional wait timeout.

## Interface
Parameters:
- WAIT_LIMIT, 0: maximum cycles to wait for mem_ready in one memory state; 0 disables the timeout.
- TMR_W, 8: width of the wait counter; WAIT_LIMIT < 2^TMR_W.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write, pc_write_cond  out  1  unconditional PC load; PC load if ALU zero.
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1  memory strobes.
- ir_write, mdr_write  out  1  IR load; memory data register load.
- mem_to_reg, reg_dst, reg_write  out  1  writeback source (1 = MDR); destination (1 = rd); register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- bus_error  out  1  sticky; set by a wait timeout.
- state  out  4  current state, for debug.

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 12.
- Outputs are a Moore decode of state, gated with mem_ready where noted. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, which forms the branch target in ALUOut. Next state by opcode:
  - 0x00 → EXECUTE
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EX
  - any other opcode → pulse illegal_op, then FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: mem_read=1, i_or_d=1, mdr_write=mem_ready. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Stay until mem_ready, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Wait counter: cleared on entry to FETCH, MEM_READ or MEM_WRITE, and incremented each cycle spent waiting there. If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT without mem_ready, go to HALT and set bus_error.
- If mem_ready arrives on the same cycle the counter reaches WAIT_LIMIT, mem_ready wins and no error is raised.
- HALT: all strobes and enables are 0. The block stays in HALT until reset.

## Timing
- Reset: state=FETCH, counter=0, bus_error=0, illegal_op=0. While reset is high, every write enable and strobe is forced to 0.
- The first FETCH is visible in the cycle after reset is released.
- Instruction latency with zero-wait memory (mem_ready tied to 1):
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is sampled only in FETCH, MEM_READ and MEM_WRITE; in all other states it is ignored.
- Write pulses (ir_write, pc_write, mdr_write) last exactly one cycle for each completed access.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted in that cycle.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the 4-bit state encodings
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the alu_src_b, alu_op and pc_source encodings
- The block contains the state register, the wait counter and the next-state logic.
- Output decode lives in one combinational sub-module, `mc_ctrl_decode`, with inputs state, mem_ready and reset and outputs the control vector.

## Test plan
- Reset held for 3 cycles with mem_ready=1 → all enables are 0. In the cycle after release: state=0, mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- lw (opcode 0x23) with zero-wait memory → state sequence 0,1,2,3,4,0. alu_src_b=10 in state 2, mdr_write=1 in state 3, reg_write=1 and mem_to_reg=1 in state 4.
- sw (opcode 0x2B) with mem_ready low for 3 cycles in MEM_WRITE → mem_write stays high for 4 cycles, then state 0. bus_error remains 0 with WAIT_LIMIT=0.
- beq (opcode 0x04) then j (opcode 0x02) → DECODE shows alu_src_b=11. BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01. JUMP shows pc_write=1, pc_source=10.
- Opcode 0x3F → illegal_op is high for exactly 1 cycle in DECODE, then state 0. No reg_write or pc_write is asserted.
- WAIT_LIMIT=4 and mem_ready held at 0 in FETCH → HALT after 4 waiting cycles with bus_error=1. HALT persists with mem_ready=1. Reset clears bus_error and returns state to 0.
